mem_block_responder: RTL and testbench

MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

---
 rtl/mem_block_responder.sv | 115 +++++++++++
 tb/tb_mem_block_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// Block-transfer memory responder.
// A read or write request is accepted while idle; after a fixed latency the
// whole aligned block is either returned on data_out or committed to storage,
// signalled by a one-cycle ready/hit pulse.
//
// state | meaning
// IDLE  | waiting for a request; accepts on any edge with read or write high
// BUSY  | latency countdown; request inputs ignored
// RESP  | completion cycle; ready=hit=1, read data on data_out
module mem_block_responder #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 32,
  parameter int LATENCY    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             hit,
  output logic                             ready,
  output logic                             busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OFF   = $clog2(BLOCK_SIZE);
  localparam int BW    = ADDR_WIDTH - OFF;
  localparam int LW    = BLOCK_SIZE * DATA_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Storage is one flat vector; lane 0 of a block sits at its lowest bits, so
  // a whole block is a single contiguous LW-wide slice.
  function automatic logic [DEPTH*DATA_WIDTH-1:0] init_image();
    logic [DEPTH*DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i);
    return v;
  endfunction

  localparam logic [DEPTH*DATA_WIDTH-1:0] INIT_IMAGE = init_image();

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q;
  logic [BW-1:0]             blk_q;
  logic                      is_wr_q;
  logic [LW-1:0]             wdata_q;
  logic [DEPTH*DATA_WIDTH-1:0] mem_q;
  logic                      accept;
  logic                      resp_enter;
  logic                      unused_low;

  // Offset bits inside a block never select anything.
  assign unused_low = ^addr[OFF-1:0];

  assign accept     = (state_q == IDLE) && (read || write);
  assign resp_enter = (state_q == BUSY) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read || write) state_d = BUSY;
      BUSY:    if (cnt_q == '0)   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency down-counter: loaded at acceptance, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt_q <= '0;
    else if (accept)                           cnt_q <= CW'(LATENCY - 1);
    else if (state_q == BUSY && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  // Request capture; write wins when both read and write are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q   <= '0;
      is_wr_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      blk_q   <= addr[ADDR_WIDTH-1:OFF];
      is_wr_q <= write;
      wdata_q <= data_in;
    end
  end

  // Block storage and read-data register, both updated on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= INIT_IMAGE;
      data_out <= '0;
    end else if (resp_enter) begin
      if (is_wr_q) mem_q[int'(blk_q)*LW +: LW] <= wdata_q;
      else         data_out <= mem_q[int'(blk_q)*LW +: LW];
    end
  end

  assign ready = (state_q == RESP);
  assign hit   = (state_q == RESP);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_block_responder.sv
// Testbench for mem_block_responder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (byte array + completion timestamp).
module tb_mem_block_responder;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int BS = 32;
  localparam int L  = 4;
  localparam int LW = BS * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          read = 1'b0, write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] data_in = '0, data_out;
  logic          hit, ready, busy;

  logic          read1 = 1'b0, write1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [LW-1:0] data_in1 = '0, data_out1;
  logic          hit1, ready1, busy1;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_block_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .hit(hit), .ready(ready), .busy(busy));

  mem_block_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .read(read1), .write(write1), .addr(addr1),
    .data_in(data_in1), .data_out(data_out1), .hit(hit1), .ready(ready1), .busy(busy1));

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] ramp(input int start);
    logic [LW-1:0] v;
    for (int j = 0; j < BS; j++) v[j*DW +: DW] = 8'(start + j);
    return v;
  endfunction

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    logic [LW-1:0] v;
    for (int j = 0; j < BS; j++) v[j*DW +: DW] = b;
    return v;
  endfunction

  // Transaction-level model: one outstanding request, completing L edges
  // after acceptance, idle again one edge later.
  logic [7:0]    mm [2**AW];
  bit            m_pend, m_ready, m_busy, m_wr;
  logic [LW-1:0] m_data, m_wd;
  int            m_edge, m_resp, m_base;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mm[i] = 8'(i);
      m_pend = 0; m_ready = 0; m_busy = 0; m_wr = 0;
      m_data = '0; m_wd = '0; m_edge = 0; m_resp = 0; m_base = 0;
    end else begin
      m_edge++;
      if (m_pend && m_edge == m_resp) begin
        m_ready = 1;
        if (m_wr) for (int j = 0; j < BS; j++) mm[m_base + j] = m_wd[j*DW +: DW];
        else      for (int j = 0; j < BS; j++) m_data[j*DW +: DW] = mm[m_base + j];
      end else if (m_pend && m_edge == m_resp + 1) begin
        m_pend = 0; m_ready = 0; m_busy = 0;
      end else if (!m_pend && (read || write)) begin
        m_pend = 1; m_busy = 1;
        m_resp = m_edge + L;
        m_wr   = write;
        m_base = int'(addr) & ~(BS - 1);
        m_wd   = data_in;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", {255'b0, ready}, {255'b0, m_ready});
      chk("hit",   {255'b0, hit},   {255'b0, m_ready});
      chk("busy",  {255'b0, busy},  {255'b0, m_busy});
      chk("data_out", data_out, m_data);
    end
  end

  task automatic issue(input bit r, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clk); #1;
    read = r; write = w; addr = a; data_in = d;
    @(negedge clk); #1;
    read = 0; write = 0;
  endtask

  // Called just after the acceptance edge; waits for ready, bounded.
  task automatic wait_ready(input string nm, output logic [LW-1:0] dq);
    int e, nb;
    e = 0; nb = 0;
    while (1) begin
      if (ready || e >= 20) break;
      if (busy) nb++;
      @(negedge clk);
      e++;
    end
    chk({nm, "_latency"}, LW'(e), LW'(L));
    chk({nm, "_busy_cycles"}, LW'(nb), LW'(L));
    dq = data_out;
  endtask

  initial begin
    logic [LW-1:0] dq, rd;
    int            npulse;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_ready", {255'b0, ready}, '0);
    chk("rst_busy",  {255'b0, busy},  '0);
    chk("rst_data",  data_out, '0);
    chk("rst_ready1", {255'b0, ready1}, '0);
    chk("rst_data1", data_out1, '0);
    #1 rst_n = 1'b1;

    // LATENCY=1 instance: reads held high back to back.
    @(negedge clk); #1; read1 = 1; addr1 = 11'h000;
    @(negedge clk);
    chk("l1_e0_ready", {255'b0, ready1}, '0);
    chk("l1_e0_busy",  {255'b0, busy1},  LW'(1));
    @(negedge clk);
    chk("l1_e1_ready", {255'b0, ready1}, LW'(1));
    chk("l1_e1_hit",   {255'b0, hit1},   LW'(1));
    chk("l1_e1_data",  data_out1, ramp(8'h00));
    #1 addr1 = 11'h020;
    @(negedge clk);
    chk("l1_e2_ready", {255'b0, ready1}, '0);
    chk("l1_e2_busy",  {255'b0, busy1},  '0);
    @(negedge clk);
    chk("l1_e3_ready", {255'b0, ready1}, '0);
    chk("l1_e3_busy",  {255'b0, busy1},  LW'(1));
    #1 read1 = 0;
    @(negedge clk);
    chk("l1_e4_ready", {255'b0, ready1}, LW'(1));
    chk("l1_e4_data",  data_out1, ramp(8'h20));

    // Plain read after reset.
    issue(1, 0, 11'h040, '0);
    wait_ready("rd040", dq);
    chk("rd040_data", dq, ramp(8'h40));
    chk("rd040_model", m_data, ramp(8'h40));

    // Write with unaligned address, read back, neighbour untouched.
    issue(0, 1, 11'h7E3, fill(8'hFF));
    wait_ready("wr7e3", dq);
    chk("wr7e3_keeps_data", dq, ramp(8'h40));
    issue(1, 0, 11'h7E0, '0);
    wait_ready("rd7e0", dq);
    chk("rd7e0_data", dq, fill(8'hFF));
    issue(1, 0, 11'h7C0, '0);
    wait_ready("rd7c0", dq);
    chk("rd7c0_data", dq, ramp(8'hC0));

    // Request during BUSY is dropped.
    issue(1, 0, 11'h100, '0);
    @(negedge clk); #1; read = 1; addr = 11'h200;
    @(negedge clk); #1; read = 0;
    npulse = 0; rd = '0;
    for (int e = 2; e < 14; e++) begin
      if (ready) begin npulse++; rd = data_out; end
      @(negedge clk); #1;
    end
    chk("busy_drop_pulses", LW'(npulse), LW'(1));
    chk("busy_drop_data", rd, ramp(8'h00));

    // Read and write together is a write.
    issue(1, 1, 11'h020, fill(8'hAA));
    wait_ready("rw020", dq);
    issue(1, 0, 11'h020, '0);
    wait_ready("rd020", dq);
    chk("rd020_data", dq, fill(8'hAA));
    chk("rd020_model", m_data, fill(8'hAA));

    // Reset mid-write aborts it.
    issue(0, 1, 11'h300, fill(8'h55));
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_ready", {255'b0, ready}, '0);
      chk("abort_busy",  {255'b0, busy},  '0);
    end
    #1 rst_n = 1'b1;
    issue(1, 0, 11'h300, '0);
    wait_ready("rd300", dq);
    chk("rd300_data", dq, ramp(8'h00));

    // Randomized traffic, including occasional resets and requests while busy.
    for (int it = 0; it < 1500; it++) begin
      int sel;
      @(negedge clk); #1;
      sel   = int'($urandom_range(0, 5));
      read  = (sel == 1 || sel == 3 || sel == 4);
      write = (sel == 2 || sel == 3);
      if ($urandom_range(0, 1) == 0) addr = AW'($urandom_range(0, 2**AW - 1));
      else addr = AW'($urandom_range(0, 3) * BS + $urandom_range(0, BS - 1));
      for (int q = 0; q < LW / 32; q++) data_in[q*32 +: 32] = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk); #1;
    read = 0; write = 0; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
